// File: rtl/addrgen_seq_if.sv
// Shared types and the job/handshake bundle between the tensor-core control,
// the address-generator sequencer and the address generator itself.
//
// params::datatype_t  tile datatype (FP32 / FP16 / INT8 / INT4)
// params::addrgen_t   {datatype, rc} configuration word for the generator
//
// addrgen_seq_if signals:
//   start, cfg_datatype, cfg_rc, stall, abort   -> into the sequencer
//   agen_addrs, agen_clr, agen_en, agen_cm      -> sequencer to generator
//   busy, done, err                             -> sequencer status
// modport master: the controlling side; modport slave: the sequencer.
package params;
  typedef enum logic [1:0] {
    FP32 = 2'd0,
    FP16 = 2'd1,
    INT8 = 2'd2,
    INT4 = 2'd3
  } datatype_t;

  typedef struct packed {
    datatype_t   datatype;
    logic [1:0]  rc;
  } addrgen_t;
endpackage

interface addrgen_seq_if;
  import params::*;

  logic       start;
  datatype_t  cfg_datatype;
  logic [1:0] cfg_rc;
  logic       stall;
  logic       abort;
  addrgen_t   agen_addrs;
  logic       agen_clr;
  logic       agen_en;
  logic       agen_cm;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start, cfg_datatype, cfg_rc, stall, abort,
    input  agen_addrs, agen_clr, agen_en, agen_cm, busy, done, err
  );

  modport slave (
    input  start, cfg_datatype, cfg_rc, stall, abort,
    output agen_addrs, agen_clr, agen_en, agen_cm, busy, done, err
  );
endinterface

// File: rtl/addrgen_seq.sv
// addrgen_seq: job sequencer for the row/column SRAM address generator that
// feeds the systolic array. A job latches {datatype, rc}, pulses a reinit,
// issues exactly N generator enables (N depends on datatype, stall freezes
// issue), waits DRAIN_CYCLES for the array skew to empty, then pulses done.
//
// Ports:
//   clk   clock, posedge
//   rst   synchronous active-high reset
//   bus   addrgen_seq_if.slave
//         in : start, cfg_datatype, cfg_rc, stall, abort
//         out: agen_addrs, agen_clr, agen_en, agen_cm, busy, done, err
// agen_en / agen_cm are combinational (so abort/stall gate them in the same
// cycle); every other output is registered.
module addrgen_seq #(
  parameter int DRAIN_CYCLES = 8,
  parameter int CNT_W        = 7
) (
  input  logic          clk,
  input  logic          rst,
  addrgen_seq_if.slave  bus
);
  import params::*;

  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] issue_cnt;
  logic [DRN_W-1:0] drain_cnt;
  logic             issue_last;

  // Enables per job minus one, so the counter reaches zero on the final issue.
  function automatic logic [CNT_W-1:0] issue_len_m1(input datatype_t dt);
    case (dt)
      FP32:    return CNT_W'(63);
      FP16:    return CNT_W'(63);
      INT8:    return CNT_W'(15);
      default: return CNT_W'(7);
    endcase
  endfunction

  assign issue_last  = (issue_cnt == '0);
  assign bus.agen_en = (state == S_ISSUE) && !bus.stall && !bus.abort;
  assign bus.agen_cm = bus.agen_en && issue_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      issue_cnt      <= '0;
      drain_cnt      <= '0;
      bus.agen_addrs <= '{datatype: FP32, rc: 2'b00};
      bus.agen_clr   <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      bus.agen_clr <= 1'b0;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            // INT4 has no row/col distinction, so rc=11 is harmless there.
            if (bus.cfg_rc == 2'b11 && bus.cfg_datatype != INT4) begin
              bus.err <= 1'b1;
            end else begin
              bus.agen_addrs <= '{datatype: bus.cfg_datatype, rc: bus.cfg_rc};
              bus.agen_clr   <= 1'b1;
              bus.busy       <= 1'b1;
              state          <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (bus.abort) begin
            state    <= S_IDLE;
            bus.busy <= 1'b0;
          end else begin
            issue_cnt <= issue_len_m1(bus.agen_addrs.datatype);
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.abort) begin
            state    <= S_IDLE;
            bus.busy <= 1'b0;
          end else if (bus.agen_en) begin
            if (issue_last) begin
              drain_cnt <= DRN_W'(DRAIN_CYCLES - 1);
              state     <= S_DRAIN;
            end else begin
              issue_cnt <= issue_cnt - 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (bus.abort) begin
            state    <= S_IDLE;
            bus.busy <= 1'b0;
          end else if (drain_cnt == '0) begin
            bus.done <= 1'b1;
            state    <= S_DONE;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_addrgen_seq.sv
// Bench for addrgen_seq: directed job scenarios followed by random traffic,
// every cycle compared against a job-level reference model (enables given,
// drain cycles elapsed), plus literal timing expectations for known jobs.
module tb_addrgen_seq;
  import params::*;

  localparam int DRAIN = 8;

  logic clk = 1'b0;
  logic rst;
  addrgen_seq_if bus ();

  addrgen_seq #(.DRAIN_CYCLES(DRAIN), .CNT_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model state: job-level quantities only
  bit         m_job;
  int         m_age;
  int         m_issued;
  int         m_drain;
  int         m_n;
  logic [3:0] m_addrs;
  bit         m_err;

  // observed DUT events since the last start request
  int acc_cyc, en_cnt, first_en, cm_cyc, done_cyc, err_cyc, clr_cnt, busy_cnt;

  function automatic int n_of(input datatype_t d);
    case (d)
      FP32:    return 64;
      FP16:    return 64;
      INT8:    return 16;
      default: return 8;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_track();
    acc_cyc = cyc; en_cnt = 0; first_en = -1; cm_cyc = -1;
    done_cyc = -1; err_cyc = -1; clr_cnt = 0; busy_cnt = 0;
  endtask

  task automatic step(input logic s, input datatype_t d, input logic [1:0] r,
                      input logic st, input logic ab, input logic rs);
    bit e_busy, e_clr, e_en, e_cm, e_done, issuing;
    @(negedge clk);
    rst              = rs;
    bus.start        = s;
    bus.cfg_datatype = d;
    bus.cfg_rc       = r;
    bus.stall        = st;
    bus.abort        = ab;
    #1;
    e_busy  = m_job;
    e_clr   = m_job && (m_age == 1);
    issuing = m_job && (m_age >= 2) && (m_issued < m_n);
    e_en    = issuing && !st && !ab;
    e_cm    = e_en && (m_issued == m_n - 1);
    e_done  = m_job && (m_issued == m_n) && (m_drain == DRAIN);
    chk("busy",  32'(bus.busy),       32'(e_busy));
    chk("clr",   32'(bus.agen_clr),   32'(e_clr));
    chk("en",    32'(bus.agen_en),    32'(e_en));
    chk("cm",    32'(bus.agen_cm),    32'(e_cm));
    chk("done",  32'(bus.done),       32'(e_done));
    chk("err",   32'(bus.err),        32'(m_err));
    chk("addrs", 32'(bus.agen_addrs), 32'(m_addrs));
    if (bus.agen_en === 1'b1) begin
      en_cnt++;
      if (first_en < 0) first_en = cyc;
    end
    if (bus.agen_cm === 1'b1)  cm_cyc   = cyc;
    if (bus.done === 1'b1)     done_cyc = cyc;
    if (bus.err === 1'b1)      err_cyc  = cyc;
    if (bus.agen_clr === 1'b1) clr_cnt++;
    if (bus.busy === 1'b1)     busy_cnt++;
    // advance the model to the state after this clock edge
    if (rs) begin
      m_job = 0; m_addrs = 4'h0; m_err = 0;
    end else begin
      m_err = 0;
      if (m_job) begin
        if (e_done || ab) m_job = 0;
        else begin
          m_age++;
          if (e_en) m_issued++;
          else if (m_issued == m_n) m_drain++;
        end
      end else if (s) begin
        clear_track();
        if (r == 2'b11 && d != INT4) m_err = 1;
        else begin
          m_job = 1; m_age = 1; m_issued = 0; m_drain = 0;
          m_n = n_of(d); m_addrs = {d, r};
        end
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, FP32, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.cfg_datatype = FP32; bus.cfg_rc = 2'b00;
    bus.stall = 1'b0; bus.abort = 1'b0;
    m_job = 0; m_age = 0; m_issued = 0; m_drain = 0; m_n = 0;
    m_addrs = 4'h0; m_err = 0;
    clear_track();
    repeat (2) @(negedge clk);

    // reset state
    idle(2);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_addrs", 32'(bus.agen_addrs), 32'd0);

    // FP32 rc=00, no stall
    step(1'b1, FP32, 2'b00, 1'b0, 1'b0, 1'b0);
    idle(80);
    chk("fp32_en_cnt", 32'(en_cnt), 32'd64);
    chk("fp32_first",  32'(first_en - acc_cyc), 32'd2);
    chk("fp32_cm",     32'(cm_cyc - acc_cyc), 32'd65);
    chk("fp32_done",   32'(done_cyc - acc_cyc), 32'd74);
    chk("fp32_busy",   32'(busy_cnt), 32'd74);

    // INT8 rc=01 with a 3-cycle stall mid-issue
    step(1'b1, INT8, 2'b01, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 40; k++)
      step(1'b0, FP32, 2'b00, (k >= 8 && k <= 10), 1'b0, 1'b0);
    chk("int8_en_cnt", 32'(en_cnt), 32'd16);
    chk("int8_done",   32'(done_cyc - acc_cyc), 32'd29);

    // INT4 with rc=11 is legal
    step(1'b1, INT4, 2'b11, 1'b0, 1'b0, 1'b0);
    idle(25);
    chk("int4_en_cnt", 32'(en_cnt), 32'd8);
    chk("int4_done",   32'(done_cyc - acc_cyc), 32'd18);
    chk("int4_err",    32'(err_cyc), 32'hffff_ffff);

    // FP16 with rc=11 is rejected
    step(1'b1, FP16, 2'b11, 1'b0, 1'b0, 1'b0);
    idle(4);
    chk("fp16bad_err",  32'(err_cyc - acc_cyc), 32'd1);
    chk("fp16bad_clr",  32'(clr_cnt), 32'd0);
    chk("fp16bad_busy", 32'(busy_cnt), 32'd0);

    // abort on the 10th enable of FP16, then immediate restart
    step(1'b1, FP16, 2'b00, 1'b0, 1'b0, 1'b0);
    idle(10);
    step(1'b0, FP32, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("abort_en_cnt", 32'(en_cnt), 32'd9);
    step(1'b1, INT4, 2'b10, 1'b0, 1'b0, 1'b0);
    chk("abort_no_done", 32'(done_cyc), 32'hffff_ffff);
    idle(25);
    chk("restart_done", 32'(done_cyc - acc_cyc), 32'd18);

    // start held through a job while cfg changes
    step(1'b1, INT4, 2'b01, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      if (k <= 4) step(1'b1, INT4, 2'b01, 1'b0, 1'b0, 1'b0);
      else        step(1'b1, FP16, 2'b10, 1'b0, 1'b0, 1'b0);
      if (k == 18) begin
        chk("held_done",  32'(bus.done), 32'd1);
        chk("held_addrs", 32'(bus.agen_addrs), 32'hd);
      end
      if (k == 20) begin
        chk("held_reload", 32'(bus.agen_clr), 32'd1);
        chk("held_addrs2", 32'(bus.agen_addrs), 32'h6);
      end
    end
    idle(80);

    // reset during DRAIN
    step(1'b1, INT4, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 25; k++)
      step(1'b0, FP32, 2'b00, 1'b0, 1'b0, (k == 12));
    chk("rst_drain_no_done", 32'(done_cyc), 32'hffff_ffff);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 2) == 0),
           datatype_t'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 299) == 0));
    end
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
